debounce_sync: RTL and testbench

- Upstream conditioning stage for the positive-edge detector. Takes a raw asynchronous level input, such as a push-button or external strobe.
- Synchronises the input into clk, then rejects bounces and glitches shorter than DEBOUNCE_CYCLES.
- Presents a clean, registered level on dout, which drives the edge detector's din.
- Also reports settling status and aborted transitions for diagnostics.

---
 rtl/debounce_sync.sv | 127 ++++++++++++
 tb/tb_debounce_sync.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level into clk and only passes a new level to
// dout after it has held for DEBOUNCE_CYCLES; aborted candidates are reported.
module debounce_sync #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_WIDTH       = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_async,
    input  logic       i_clr_glitch,
    output logic       dout,
    output logic       o_settling,
    output logic       o_glitch,
    output logic [7:0] o_glitch_count
);

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_CHK_HI    = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_CHK_LO    = 2'd3;
    localparam logic [1:0] ST_RESET     = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_dout;
    logic                   r_glitch;
    logic [7:0]             r_glitch_count;

    logic                   w_s;
    logic [1:0]             w_state_next;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic                   w_dout_next;
    logic                   w_glitch_evt;

    // Plain flop chain: nothing but the previous stage may feed these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din_async};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dout_next  = r_dout;
        w_glitch_evt = 1'b0;
        case (r_state)
            ST_STABLE_LO: begin
                if (w_s) begin
                    w_state_next = ST_CHK_HI;
                    w_cnt_next   = '0;
                end
            end
            ST_CHK_HI: begin
                if (!w_s) begin
                    w_state_next = ST_STABLE_LO;
                    w_glitch_evt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_STABLE_HI;
                    w_dout_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_STABLE_HI: begin
                if (!w_s) begin
                    w_state_next = ST_CHK_LO;
                    w_cnt_next   = '0;
                end
            end
            ST_CHK_LO: begin
                if (w_s) begin
                    w_state_next = ST_STABLE_HI;
                    w_glitch_evt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_STABLE_LO;
                    w_dout_next  = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RESET;
                w_dout_next  = RESET_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RESET;
            r_cnt    <= '0;
            r_dout   <= RESET_LEVEL;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_dout   <= w_dout_next;
            r_glitch <= w_glitch_evt;
        end
    end

    // A clear on the same cycle as an abort wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_glitch_count <= '0;
        end else if (i_clr_glitch) begin
            r_glitch_count <= '0;
        end else if (w_glitch_evt && (r_glitch_count != 8'hFF)) begin
            r_glitch_count <= r_glitch_count + 8'd1;
        end
    end

    assign dout           = r_dout;
    assign o_settling     = (r_state == ST_CHK_HI) || (r_state == ST_CHK_LO);
    assign o_glitch       = r_glitch;
    assign o_glitch_count = r_glitch_count;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: two instances (RESET_LEVEL 0 / D=4 and
// RESET_LEVEL 1 / D=1) checked each cycle against a run-length model.
module tb_debounce_sync;

    localparam int D_A = 4;
    localparam int D_B = 1;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din_a = 1'b0;
    logic din_b = 1'b1;
    logic clr_a = 1'b0;
    logic clr_b = 1'b0;

    logic       dout_a, settling_a, glitch_a;
    logic [7:0] gcnt_a;
    logic       dout_b, settling_b, glitch_b;
    logic [7:0] gcnt_b;

    int total = 0;
    int bad = 0;
    int pedge_cnt = 0;
    logic prev_dout_a = 1'b0;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(D_A), .CNT_WIDTH(8), .RESET_LEVEL(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .din_async(din_a), .i_clr_glitch(clr_a),
        .dout(dout_a), .o_settling(settling_a), .o_glitch(glitch_a), .o_glitch_count(gcnt_a)
    );

    debounce_sync #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(D_B), .CNT_WIDTH(16), .RESET_LEVEL(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .din_async(din_b), .i_clr_glitch(clr_b),
        .dout(dout_b), .o_settling(settling_b), .o_glitch(glitch_b), .o_glitch_count(gcnt_b)
    );

    // Model: a new level is accepted once s has differed from dout at D+1
    // consecutive sampling edges; a run that ends early is a glitch.
    typedef struct {
        logic dout;
        int   run;
        logic glitch;
        int   count;
    } mstate_t;

    mstate_t ma, mb;
    logic qa[$];
    logic qb[$];

    function automatic mstate_t mreset(logic lvl);
        mstate_t m;
        m.dout = lvl;
        m.run = 0;
        m.glitch = 1'b0;
        m.count = 0;
        return m;
    endfunction

    function automatic mstate_t mstep(mstate_t m, logic s, logic clr, int d);
        mstate_t n = m;
        n.glitch = 1'b0;
        if (s != m.dout) begin
            n.run = m.run + 1;
            if (n.run == d + 1) begin
                n.dout = s;
                n.run = 0;
            end
        end else begin
            if (m.run > 0) n.glitch = 1'b1;
            n.run = 0;
        end
        if (clr) n.count = 0;
        else if (n.glitch && n.count < 255) n.count = n.count + 1;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma = mreset(1'b0);
            mb = mreset(1'b1);
            qa.delete();
            qb.delete();
            for (int i = 0; i < SYNC; i++) begin
                qa.push_back(1'b0);
                qb.push_back(1'b1);
            end
        end else begin
            ma = mstep(ma, qa.pop_front(), clr_a, D_A);
            mb = mstep(mb, qb.pop_front(), clr_b, D_B);
            qa.push_back(din_a);
            qb.push_back(din_b);
        end
    end

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("model_dout_a", int'(dout_a), int'(ma.dout));
            check("model_settling_a", int'(settling_a), int'(ma.run > 0));
            check("model_glitch_a", int'(glitch_a), int'(ma.glitch));
            check("model_count_a", int'(gcnt_a), ma.count);
            check("model_dout_b", int'(dout_b), int'(mb.dout));
            check("model_settling_b", int'(settling_b), int'(mb.run > 0));
            check("model_glitch_b", int'(glitch_b), int'(mb.glitch));
            check("model_count_b", int'(gcnt_b), mb.count);
        end
    end

    // Downstream positive-edge detector on dout_a.
    always @(negedge clk) begin
        if (!rst && dout_a && !prev_dout_a) pedge_cnt++;
        prev_dout_a = dout_a;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int p0;

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_dout_a", int'(dout_a), 0);
        check("rst_settling_a", int'(settling_a), 0);
        check("rst_glitch_a", int'(glitch_a), 0);
        check("rst_count_a", int'(gcnt_a), 0);
        check("rst_dout_b", int'(dout_b), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick(3);

        // Clean rise
        din_a = 1'b1;
        tick(2);
        check("rise_settling_e2", int'(settling_a), 0);
        tick(1);
        check("rise_settling_e3", int'(settling_a), 1);
        tick(3);
        check("rise_dout_e6", int'(dout_a), 0);
        check("rise_settling_e6", int'(settling_a), 1);
        tick(1);
        check("rise_dout_e7", int'(dout_a), 1);
        check("rise_settling_e7", int'(settling_a), 0);
        din_a = 1'b0;
        tick(10);
        check("fall_dout", int'(dout_a), 0);

        // Bounce: high 2, low 1, high held
        p0 = pedge_cnt;
        din_a = 1'b1;
        tick(2);
        din_a = 1'b0;
        tick(1);
        din_a = 1'b1;
        tick(2);
        check("bounce_glitch_e5", int'(glitch_a), 1);
        check("bounce_count", int'(gcnt_a), 1);
        tick(4);
        check("bounce_dout_e9", int'(dout_a), 0);
        tick(1);
        check("bounce_dout_e10", int'(dout_a), 1);
        tick(2);
        check("bounce_pedges", pedge_cnt - p0, 1);
        din_a = 1'b0;
        tick(10);

        // Sub-threshold pulses of 1, 2, 3 cycles
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("clr_count", int'(gcnt_a), 0);
        for (int w = 1; w <= 3; w++) begin
            din_a = 1'b1;
            tick(w);
            din_a = 1'b0;
            tick(6);
        end
        check("short_count", int'(gcnt_a), 3);
        check("short_dout", int'(dout_a), 0);

        // Saturation, then clear coincident with an abort
        repeat (260) begin
            din_a = 1'b1;
            tick(1);
            din_a = 1'b0;
            tick(4);
        end
        check("sat_count", int'(gcnt_a), 255);
        din_a = 1'b1;
        tick(1);
        din_a = 1'b0;
        tick(2);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("clr_glitch_pulse", int'(glitch_a), 1);
        check("clr_glitch_count", int'(gcnt_a), 0);
        tick(3);

        // Reset while qualifying with counter at 2
        din_a = 1'b1;
        tick(5);
        check("pre_rst_settling", int'(settling_a), 1);
        rst = 1'b1;
        #1;
        check("midrst_dout", int'(dout_a), 0);
        check("midrst_settling", int'(settling_a), 0);
        check("midrst_glitch", int'(glitch_a), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick(6);
        check("postrst_dout_e6", int'(dout_a), 0);
        tick(1);
        check("postrst_dout_e7", int'(dout_a), 1);

        // RESET_LEVEL=1, DEBOUNCE_CYCLES=1
        din_b = 1'b0;
        tick(3);
        check("b_fall_e3", int'(dout_b), 1);
        tick(1);
        check("b_fall_e4", int'(dout_b), 0);
        din_b = 1'b1;
        tick(3);
        check("b_rise_e3", int'(dout_b), 0);
        tick(1);
        check("b_rise_e4", int'(dout_b), 1);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
